ahb_mst_arbiter: RTL and testbench

Two-master AHB-Lite arbiter for the core's single shared instruction/data bus port. Master 0 is the instruction-fetch interface; master 1 is the load/store interface. The block selects the address-phase owner each cycle and tracks the data-phase owner. It routes slave responses back to the owning master. A per-master holding buffer ensures a completed read is never lost when that master loses the next arbitration.

---
 rtl/ahb_mst_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ahb_mst_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mst_arbiter.sv
// Two-master AHB-Lite arbiter: zero-cycle address-phase arbitration with priority,
// round-robin and bounded lock, plus a per-master read holding buffer.

`ifndef HADDR_BUS
`define HADDR_BUS [31:0]
`endif
`ifndef HDATA_BUS
`define HDATA_BUS [31:0]
`endif

module ahb_mst_arbiter #(
    parameter int LOCK_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_hsel_i,
    input  logic [1:0]      m0_htrans_i,
    input  logic `HADDR_BUS m0_haddr_i,
    input  logic `HDATA_BUS m0_hwdata_i,
    input  logic            m0_hwrite_i,
    input  logic [2:0]      m0_hsize_i,
    input  logic [2:0]      m0_hburst_i,
    input  logic [3:0]      m0_hprot_i,
    input  logic            m0_hmastlock_i,
    input  logic            m0_priority_i,
    output logic            m0_hready_o,
    output logic            m0_hresp_o,
    output logic `HDATA_BUS m0_hrdata_o,
    input  logic            m1_hsel_i,
    input  logic [1:0]      m1_htrans_i,
    input  logic `HADDR_BUS m1_haddr_i,
    input  logic `HDATA_BUS m1_hwdata_i,
    input  logic            m1_hwrite_i,
    input  logic [2:0]      m1_hsize_i,
    input  logic [2:0]      m1_hburst_i,
    input  logic [3:0]      m1_hprot_i,
    input  logic            m1_hmastlock_i,
    input  logic            m1_priority_i,
    output logic            m1_hready_o,
    output logic            m1_hresp_o,
    output logic `HDATA_BUS m1_hrdata_o,
    output logic            slv_hsel_o,
    output logic [1:0]      slv_htrans_o,
    output logic `HADDR_BUS slv_haddr_o,
    output logic `HDATA_BUS slv_hwdata_o,
    output logic            slv_hwrite_o,
    output logic [2:0]      slv_hsize_o,
    output logic [2:0]      slv_hburst_o,
    output logic [3:0]      slv_hprot_o,
    output logic            slv_hmastlock_o,
    input  logic            slv_hready_i,
    input  logic            slv_hresp_i,
    input  logic `HDATA_BUS slv_hrdata_i
);

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

    logic [1:0]      req;
    logic [1:0]      lock_req;
    logic [1:0]      pri;
    logic            any_req;
    logic            win;
    logic            lock_hold;
    logic [1:0]      mst_rdy;

    logic            dvalid;
    logic            down;
    logic            last;
    logic [3:0]      lock_cnt;
    logic [1:0]      hold_v;
    logic [1:0]      hold_resp;
    logic `HDATA_BUS hold_data [2];

    assign req      = {m1_hsel_i & m1_htrans_i[1], m0_hsel_i & m0_htrans_i[1]};
    assign lock_req = {m1_hmastlock_i, m0_hmastlock_i};
    assign pri      = {m1_priority_i, m0_priority_i};
    assign any_req  = |req;

    // A locked previous owner keeps the bus until it has used up its lock budget.
    always_comb begin
        lock_hold = req[last] & lock_req[last] & (lock_cnt < LOCK_LIM);
        win       = 1'b0;
        if (lock_hold) begin
            win = last;
        end else if (req == 2'b01) begin
            win = 1'b0;
        end else if (req == 2'b10) begin
            win = 1'b1;
        end else if (req == 2'b11) begin
            if (pri[0] != pri[1]) begin
                win = pri[1];
            end else begin
                win = ~last;
            end
        end
    end

    always_comb begin
        slv_hsel_o      = 1'b0;
        slv_htrans_o    = 2'b00;
        slv_haddr_o     = '0;
        slv_hwrite_o    = 1'b0;
        slv_hsize_o     = 3'b000;
        slv_hburst_o    = 3'b000;
        slv_hprot_o     = 4'b0000;
        slv_hmastlock_o = 1'b0;
        if (any_req && !rst) begin
            if (win) begin
                slv_hsel_o      = m1_hsel_i;
                slv_htrans_o    = m1_htrans_i;
                slv_haddr_o     = m1_haddr_i;
                slv_hwrite_o    = m1_hwrite_i;
                slv_hsize_o     = m1_hsize_i;
                slv_hburst_o    = m1_hburst_i;
                slv_hprot_o     = m1_hprot_i;
                slv_hmastlock_o = m1_hmastlock_i;
            end else begin
                slv_hsel_o      = m0_hsel_i;
                slv_htrans_o    = m0_htrans_i;
                slv_haddr_o     = m0_haddr_i;
                slv_hwrite_o    = m0_hwrite_i;
                slv_hsize_o     = m0_hsize_i;
                slv_hburst_o    = m0_hburst_i;
                slv_hprot_o     = m0_hprot_i;
                slv_hmastlock_o = m0_hmastlock_i;
            end
        end
    end

    assign slv_hwdata_o = down ? m1_hwdata_i : m0_hwdata_i;

    assign mst_rdy[0] = slv_hready_i & ~rst & (~req[0] | (win == 1'b0));
    assign mst_rdy[1] = slv_hready_i & ~rst & (~req[1] | (win == 1'b1));
    assign m0_hready_o = mst_rdy[0];
    assign m1_hready_o = mst_rdy[1];

    // A buffered read takes precedence over the live bus until its master is ready.
    assign m0_hrdata_o = hold_v[0] ? hold_data[0] : slv_hrdata_i;
    assign m1_hrdata_o = hold_v[1] ? hold_data[1] : slv_hrdata_i;
    assign m0_hresp_o  = hold_v[0] ? hold_resp[0] : (dvalid & ~down & slv_hresp_i);
    assign m1_hresp_o  = hold_v[1] ? hold_resp[1] : (dvalid & down & slv_hresp_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            dvalid    <= 1'b0;
            down      <= 1'b0;
            last      <= 1'b1;
            lock_cnt  <= 4'd0;
            hold_v    <= 2'b00;
            hold_resp <= 2'b00;
        end else if (slv_hready_i) begin
            dvalid <= any_req;
            down   <= win;
            if (any_req) begin
                last <= win;
            end
            if (any_req && (win == last)) begin
                lock_cnt <= (lock_cnt == 4'hF) ? 4'hF : lock_cnt + 4'd1;
            end else begin
                lock_cnt <= 4'd0;
            end
            for (int m = 0; m < 2; m++) begin
                if (dvalid && (down == 1'(m)) && !mst_rdy[m]) begin
                    hold_v[m]    <= 1'b1;
                    hold_data[m] <= slv_hrdata_i;
                    hold_resp[m] <= slv_hresp_i;
                end else if (hold_v[m] && mst_rdy[m]) begin
                    hold_v[m] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_mst_arbiter.sv
// Bench for ahb_mst_arbiter: directed scenarios then random traffic, checked against
// a grant-history model of the arbitration rules and per-master read mailboxes.

module tb_ahb_mst_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_hsel, m1_hsel;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [31:0] m0_haddr, m1_haddr;
    logic [31:0] m0_hwdata, m1_hwdata;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic [2:0]  m0_hburst, m1_hburst;
    logic [3:0]  m0_hprot, m1_hprot;
    logic        m0_hmastlock, m1_hmastlock;
    logic        m0_priority, m1_priority;
    logic        m0_hready, m1_hready;
    logic        m0_hresp, m1_hresp;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        slv_hsel;
    logic [1:0]  slv_htrans;
    logic [31:0] slv_haddr, slv_hwdata;
    logic        slv_hwrite;
    logic [2:0]  slv_hsize, slv_hburst;
    logic [3:0]  slv_hprot;
    logic        slv_hmastlock;
    logic        slv_hready;
    logic        slv_hresp;
    logic [31:0] slv_hrdata;

    int errors = 0;
    int checks = 0;

    // Model state: accepted-cycle grant history (-1 = idle), data-phase owner, mailboxes.
    int          hist[$];
    int          d_owner;
    int          cur_w;
    bit          e_rdy[2];
    bit          mb_v[2];
    logic [31:0] mb_data[2];
    bit          mb_resp[2];
    logic [31:0] stall_addr;

    ahb_mst_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_hsel_i(m0_hsel), .m0_htrans_i(m0_htrans), .m0_haddr_i(m0_haddr),
        .m0_hwdata_i(m0_hwdata), .m0_hwrite_i(m0_hwrite), .m0_hsize_i(m0_hsize),
        .m0_hburst_i(m0_hburst), .m0_hprot_i(m0_hprot), .m0_hmastlock_i(m0_hmastlock),
        .m0_priority_i(m0_priority), .m0_hready_o(m0_hready), .m0_hresp_o(m0_hresp),
        .m0_hrdata_o(m0_hrdata),
        .m1_hsel_i(m1_hsel), .m1_htrans_i(m1_htrans), .m1_haddr_i(m1_haddr),
        .m1_hwdata_i(m1_hwdata), .m1_hwrite_i(m1_hwrite), .m1_hsize_i(m1_hsize),
        .m1_hburst_i(m1_hburst), .m1_hprot_i(m1_hprot), .m1_hmastlock_i(m1_hmastlock),
        .m1_priority_i(m1_priority), .m1_hready_o(m1_hready), .m1_hresp_o(m1_hresp),
        .m1_hrdata_o(m1_hrdata),
        .slv_hsel_o(slv_hsel), .slv_htrans_o(slv_htrans), .slv_haddr_o(slv_haddr),
        .slv_hwdata_o(slv_hwdata), .slv_hwrite_o(slv_hwrite), .slv_hsize_o(slv_hsize),
        .slv_hburst_o(slv_hburst), .slv_hprot_o(slv_hprot), .slv_hmastlock_o(slv_hmastlock),
        .slv_hready_i(slv_hready), .slv_hresp_i(slv_hresp), .slv_hrdata_i(slv_hrdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int last_grant();
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != -1) return hist[i];
        end
        return 1;
    endfunction

    // Number of back-to-back repeat grants to the current owner, capped at 15.
    function automatic int repeat_run();
        int n = 0;
        int prev = 1;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i] != -1 && hist[i] == prev) n = (n < 15) ? n + 1 : 15;
            else n = 0;
            if (hist[i] != -1) prev = hist[i];
        end
        return n;
    endfunction

    function automatic int winner(input bit r0, input bit r1);
        int lst = last_grant();
        bit lst_locked;
        if (!r0 && !r1) return -1;
        lst_locked = (lst == 0) ? (r0 && m0_hmastlock) : (r1 && m1_hmastlock);
        if (lst_locked && repeat_run() < LOCK_MAX) return lst;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (m0_priority != m1_priority) return m1_priority ? 1 : 0;
        return 1 - lst;
    endfunction

    task automatic drive_m(input int m, input bit req, input logic [31:0] addr,
                           input bit lock, input bit pri);
        if (m == 0) begin
            m0_hsel = req; m0_htrans = req ? 2'b10 : 2'b00; m0_haddr = addr;
            m0_hmastlock = lock; m0_priority = pri; m0_hwrite = addr[2];
            m0_hwdata = $urandom;
        end else begin
            m1_hsel = req; m1_htrans = req ? 2'b10 : 2'b00; m1_haddr = addr;
            m1_hmastlock = lock; m1_priority = pri; m1_hwrite = addr[3];
            m1_hwdata = $urandom;
        end
    endtask

    task automatic eval();
        bit r0, r1;
        int w;
        @(negedge clk);
        r0 = m0_hsel && m0_htrans[1];
        r1 = m1_hsel && m1_htrans[1];
        if (rst) begin
            check("rst_hsel", 64'(slv_hsel), 64'd0);
            check("rst_htrans", 64'(slv_htrans), 64'd0);
            check("rst_m0_hready", 64'(m0_hready), 64'd0);
            check("rst_m1_hready", 64'(m1_hready), 64'd0);
            e_rdy[0] = 0; e_rdy[1] = 0; cur_w = -1;
            return;
        end
        w = winner(r0, r1);
        cur_w = w;
        e_rdy[0] = slv_hready && (!r0 || w == 0);
        e_rdy[1] = slv_hready && (!r1 || w == 1);
        check("slv_hsel", 64'(slv_hsel), 64'(w >= 0));
        check("slv_htrans", 64'(slv_htrans), (w < 0) ? 64'd0 : (w == 0) ? 64'(m0_htrans) : 64'(m1_htrans));
        check("slv_haddr", 64'(slv_haddr), (w < 0) ? 64'd0 : (w == 0) ? 64'(m0_haddr) : 64'(m1_haddr));
        check("slv_hmastlock", 64'(slv_hmastlock), (w < 0) ? 64'd0 : (w == 0) ? 64'(m0_hmastlock) : 64'(m1_hmastlock));
        if (w >= 0) check("slv_hwrite", 64'(slv_hwrite), (w == 0) ? 64'(m0_hwrite) : 64'(m1_hwrite));
        if (d_owner >= 0) check("slv_hwdata", 64'(slv_hwdata), (d_owner == 0) ? 64'(m0_hwdata) : 64'(m1_hwdata));
        check("m0_hready", 64'(m0_hready), 64'(e_rdy[0]));
        check("m1_hready", 64'(m1_hready), 64'(e_rdy[1]));
        check("m0_hrdata", 64'(m0_hrdata), mb_v[0] ? 64'(mb_data[0]) : 64'(slv_hrdata));
        check("m1_hrdata", 64'(m1_hrdata), mb_v[1] ? 64'(mb_data[1]) : 64'(slv_hrdata));
        check("m0_hresp", 64'(m0_hresp), mb_v[0] ? 64'(mb_resp[0]) : 64'(d_owner == 0 && slv_hresp));
        check("m1_hresp", 64'(m1_hresp), mb_v[1] ? 64'(mb_resp[1]) : 64'(d_owner == 1 && slv_hresp));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            hist.delete();
            d_owner = -1;
            mb_v[0] = 0; mb_v[1] = 0;
        end else if (slv_hready) begin
            for (int m = 0; m < 2; m++) begin
                if (d_owner == m && !e_rdy[m]) begin
                    mb_v[m] = 1; mb_data[m] = slv_hrdata; mb_resp[m] = slv_hresp;
                end else if (mb_v[m] && e_rdy[m]) begin
                    mb_v[m] = 0;
                end
            end
            d_owner = cur_w;
            hist.push_back(cur_w);
        end
        #1;
    endtask

    task automatic cyc();
        eval();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        d_owner = -1;
        cur_w = -1;
        m0_hsize = 3'b010; m1_hsize = 3'b010;
        m0_hburst = 3'b000; m1_hburst = 3'b000;
        m0_hprot = 4'b0011; m1_hprot = 4'b0011;
        drive_m(0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0);
        slv_hready = 1'b1; slv_hresp = 1'b0; slv_hrdata = 32'h0;
        cyc();
        cyc();
        rst = 1'b0;

        // Single master, zero-wait slave.
        for (int k = 0; k < 3; k++) begin
            drive_m(0, 1, 32'(4 * k), 0, 0);
            slv_hrdata = $urandom;
            eval();
            check("single_rdy", 64'(m0_hready), 64'd1);
            check("single_addr", 64'(slv_haddr), 64'(4 * k));
            advance();
        end
        drive_m(0, 0, 0, 0, 0);
        slv_hrdata = 32'hA5A5_0008;
        eval();
        check("single_rdata", 64'(m0_hrdata), 64'hA5A5_0008);
        advance();

        // Fixed priority: M1 high.
        drive_m(0, 1, 32'h100, 0, 0);
        drive_m(1, 1, 32'h200, 0, 1);
        for (int k = 0; k < 4; k++) begin
            slv_hrdata = $urandom;
            eval();
            check("prio_m0_rdy", 64'(m0_hready), 64'd0);
            check("prio_addr", 64'(slv_haddr), 64'h200);
            advance();
        end

        // Round-robin from reset.
        do_reset();
        drive_m(0, 1, 32'h100, 0, 0);
        drive_m(1, 1, 32'h200, 0, 0);
        for (int k = 0; k < 4; k++) begin
            eval();
            check("rr_addr", 64'(slv_haddr), (k % 2 == 0) ? 64'h100 : 64'h200);
            advance();
        end

        // Locked M0 against a continuous M1.
        do_reset();
        drive_m(0, 1, 32'h100, 1, 0);
        drive_m(1, 1, 32'h200, 0, 0);
        for (int k = 0; k < 13; k++) begin
            slv_hrdata = $urandom;
            cyc();
        end

        // Hold buffer: M0 loses the cycle its read data returns.
        do_reset();
        drive_m(1, 0, 0, 0, 0);
        drive_m(0, 1, 32'h10, 0, 0);
        cyc();
        drive_m(0, 1, 32'h14, 0, 0);
        drive_m(1, 1, 32'h200, 0, 1);
        slv_hrdata = 32'hDEAD_BEEF;
        eval();
        check("hold_lose_rdy", 64'(m0_hready), 64'd0);
        advance();
        check("hold_v_set", 64'(dut.hold_v[0]), 64'd1);
        drive_m(1, 0, 0, 0, 0);
        slv_hrdata = 32'h1234_5678;
        eval();
        check("hold_rel_rdy", 64'(m0_hready), 64'd1);
        check("hold_rel_data", 64'(m0_hrdata), 64'hDEAD_BEEF);
        advance();
        check("hold_v_clr", 64'(dut.hold_v[0]), 64'd0);
        drive_m(0, 0, 0, 0, 0);
        cyc();

        // Wait states mid-stream.
        drive_m(0, 1, 32'h300, 0, 0);
        drive_m(1, 1, 32'h400, 0, 0);
        cyc();
        cyc();
        slv_hready = 1'b0;
        eval();
        stall_addr = slv_haddr;
        advance();
        for (int k = 0; k < 2; k++) begin
            eval();
            check("stall_addr", 64'(slv_haddr), 64'(stall_addr));
            advance();
        end
        slv_hready = 1'b1;
        cyc();
        cyc();

        // Reset while a read sits in the hold buffer.
        drive_m(1, 0, 0, 0, 0);
        drive_m(0, 1, 32'h10, 0, 0);
        cyc();
        drive_m(1, 1, 32'h200, 0, 1);
        slv_hrdata = 32'hCAFE_F00D;
        cyc();
        rst = 1'b1;
        cyc();
        check("rst_hold_v", 64'(dut.hold_v), 64'd0);
        rst = 1'b0;
        drive_m(1, 0, 0, 0, 0);
        slv_hrdata = 32'h0BAD_0001;
        eval();
        check("rst_rdata", 64'(m0_hrdata), 64'h0BAD_0001);
        advance();

        // Random traffic; a master stalled on a live request keeps it stable.
        for (int k = 0; k < 400; k++) begin
            for (int m = 0; m < 2; m++) begin
                bit held;
                held = (m == 0) ? (m0_hsel && m0_htrans[1] && !e_rdy[0])
                                : (m1_hsel && m1_htrans[1] && !e_rdy[1]);
                if (!held) begin
                    drive_m(m, $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            slv_hready = ($urandom_range(0, 4) != 0);
            slv_hresp  = ($urandom_range(0, 7) == 0);
            slv_hrdata = $urandom;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
